// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: a single full adder produces one sum bit per clock, LSB first,
// under a three-state controller with a one-cycle done pulse.

module FullAdder (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);
  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));
endmodule

module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CI,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         CO
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, s_q, s_d;
  logic           c_q, c_d, co_q, co_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           fa_s, fa_co;

  FullAdder u_fa (
    .A  (a_q[0]),
    .B  (b_q[0]),
    .CI (c_q),
    .S  (fa_s),
    .CO (fa_co)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = CI;
          s_d     = '0;
          co_d    = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        // Sum bits enter at the MSB so that after N shifts bit 0 holds the first sum.
        s_d   = {fa_s, s_q[N-1:1]};
        c_d   = fa_co;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          co_d    = fa_co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign CO   = co_q;
endmodule
